// File: rtl/irq_controller.sv
// Machine-level interrupt sources: mtime/mtimecmp timer, msip, synchronised external line.
// A short hold window after each accepted trap keeps the request low while trap entry completes.
module irq_controller #(
    parameter int TIMER_DIV   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq_in,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        mstatus_mie,
    input  logic [31:0] mie,
    input  logic        trap_taken,
    output logic        interrupt,
    output logic [4:0]  irq_cause,
    output logic [31:0] mip
);
    localparam int PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMER_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD1 = 2'd1;
    localparam logic [1:0] ST_HOLD2 = 2'd2;
    localparam logic [1:0] ST_HOLD3 = 2'd3;

    localparam logic [2:0] W_MTIME_LO = 3'd0;
    localparam logic [2:0] W_MTIME_HI = 3'd1;
    localparam logic [2:0] W_CMP_LO   = 3'd2;
    localparam logic [2:0] W_CMP_HI   = 3'd3;
    localparam logic [2:0] W_MSIP     = 3'd4;

    logic [PRE_W-1:0]       prescale_q, prescale_d;
    logic [63:0]            mtime_q, mtime_d;
    logic [63:0]            mtimecmp_q, mtimecmp_d;
    logic                   msip_q, msip_d;
    logic                   mtip_q, mtip_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [31:0]            bus_rdata_q, bus_rdata_d;

    logic [2:0]  word;
    logic        tick;
    logic [31:0] read_word;
    logic [31:0] pending;
    logic [31:0] enabled;
    logic        unused_addr;

    assign word        = bus_addr[4:2];
    assign unused_addr = ^bus_addr[1:0];

    // Bus writes win over the timer increment; the unwritten half is left as is.
    always_comb begin
        tick       = (prescale_q == PRE_LAST);
        prescale_d = tick ? '0 : prescale_q + 1'b1;

        mtime_d = mtime_q;
        if (bus_we && word == W_MTIME_LO) begin
            mtime_d[31:0] = bus_wdata;
        end else if (bus_we && word == W_MTIME_HI) begin
            mtime_d[63:32] = bus_wdata;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        mtimecmp_d = mtimecmp_q;
        if (bus_we && word == W_CMP_LO) begin
            mtimecmp_d[31:0] = bus_wdata;
        end
        if (bus_we && word == W_CMP_HI) begin
            mtimecmp_d[63:32] = bus_wdata;
        end

        msip_d = msip_q;
        if (bus_we && word == W_MSIP) begin
            msip_d = bus_wdata[0];
        end

        mtip_d = (mtime_q >= mtimecmp_q);
        sync_d = {sync_q[SYNC_STAGES-2:0], ext_irq_in};
    end

    always_comb begin
        read_word = 32'd0;
        case (word)
            W_MTIME_LO: read_word = mtime_q[31:0];
            W_MTIME_HI: read_word = mtime_q[63:32];
            W_CMP_LO:   read_word = mtimecmp_q[31:0];
            W_CMP_HI:   read_word = mtimecmp_q[63:32];
            W_MSIP:     read_word = {31'd0, msip_q};
            default:    read_word = 32'd0;
        endcase
        bus_rdata_d = bus_re ? read_word : bus_rdata_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (trap_taken) state_d = ST_HOLD1;
            ST_HOLD1: state_d = ST_HOLD2;
            ST_HOLD2: state_d = ST_HOLD3;
            ST_HOLD3: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q  <= '0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            bus_rdata_q <= 32'd0;
        end else begin
            prescale_q  <= prescale_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            sync_q      <= sync_d;
            state_q     <= state_d;
            bus_rdata_q <= bus_rdata_d;
        end
    end

    // Priority among enabled sources: external, then software, then timer.
    always_comb begin
        pending = {20'd0, sync_q[SYNC_STAGES-1], 3'd0, mtip_q, 3'd0, msip_q, 3'd0};
        enabled = pending & mie;
        if (enabled[11]) begin
            irq_cause = 5'd11;
        end else if (enabled[3]) begin
            irq_cause = 5'd3;
        end else if (enabled[7]) begin
            irq_cause = 5'd7;
        end else begin
            irq_cause = 5'd0;
        end
        interrupt = mstatus_mie & (|enabled) & (state_q == ST_IDLE);
    end

    assign mip       = pending;
    assign bus_rdata = bus_rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomised and directed bench for irq_controller against a cycle-level
// behavioural model of the timer, msip, synchroniser delay and hold window.
module tb_irq_controller;
    localparam int TIMER_DIV   = 1;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_irq_in;
    logic        bus_we;
    logic        bus_re;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        mstatus_mie;
    logic [31:0] mie;
    logic        trap_taken;
    logic        interrupt;
    logic [4:0]  irq_cause;
    logic [31:0] mip;

    int checks   = 0;
    int failures = 0;

    longint unsigned m_mtime;
    longint unsigned m_cmp;
    int              m_pre;
    bit              m_msip;
    bit              m_mtip;
    bit              m_ext_hist[$];
    int              m_hold;
    logic [31:0]     m_rdata;

    irq_controller #(
        .TIMER_DIV   (TIMER_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq_in  (ext_irq_in),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .mstatus_mie (mstatus_mie),
        .mie         (mie),
        .trap_taken  (trap_taken),
        .interrupt   (interrupt),
        .irq_cause   (irq_cause),
        .mip         (mip)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic void model_reset();
        m_mtime = 64'd0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_pre   = 0;
        m_msip  = 1'b0;
        m_mtip  = 1'b0;
        m_ext_hist.delete();
        m_hold  = 0;
        m_rdata = 32'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        case (addr[4:2])
            3'd0:    return m_mtime[31:0];
            3'd1:    return m_mtime[63:32];
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_mip();
        bit meip;
        meip = (m_ext_hist.size() == SYNC_STAGES) ? m_ext_hist[0] : 1'b0;
        return (32'(meip) << 11) | (32'(m_mtip) << 7) | (32'(m_msip) << 3);
    endfunction

    // One clock edge of the reference: everything is computed from pre-edge values.
    function automatic void model_edge(input logic we, input logic re, input logic [4:0] addr,
                                       input logic [31:0] wdata, input logic trap, input logic ext);
        logic [31:0] rd;
        bit          tick;
        rd   = model_read(addr);
        tick = (m_pre == TIMER_DIV - 1);
        if (re) m_rdata = rd;
        m_mtip = (m_mtime >= m_cmp);
        m_ext_hist.push_back(ext);
        if (m_ext_hist.size() > SYNC_STAGES) void'(m_ext_hist.pop_front());
        if (m_hold > 0) m_hold--;
        else if (trap) m_hold = 3;
        m_pre = tick ? 0 : m_pre + 1;
        if (we && addr[4:2] == 3'd0)      m_mtime = {m_mtime[63:32], wdata};
        else if (we && addr[4:2] == 3'd1) m_mtime = {wdata, m_mtime[31:0]};
        else if (tick)                    m_mtime = m_mtime + 64'd1;
        if (we && addr[4:2] == 3'd2) m_cmp = {m_cmp[63:32], wdata};
        if (we && addr[4:2] == 3'd3) m_cmp = {wdata, m_cmp[31:0]};
        if (we && addr[4:2] == 3'd4) m_msip = wdata[0];
    endfunction

    task automatic checkAll();
        logic [31:0] exp_mip;
        logic [31:0] en;
        logic [4:0]  exp_cause;
        logic        exp_int;
        exp_mip = model_mip();
        en      = exp_mip & mie;
        if (en[11])     exp_cause = 5'd11;
        else if (en[3]) exp_cause = 5'd3;
        else if (en[7]) exp_cause = 5'd7;
        else            exp_cause = 5'd0;
        exp_int = mstatus_mie && (en != 0) && (m_hold == 0);
        checkOutput("mip", mip, exp_mip);
        checkOutput("irq_cause", irq_cause, exp_cause);
        checkOutput("interrupt", interrupt, exp_int);
        checkOutput("bus_rdata", bus_rdata, m_rdata);
    endtask

    task automatic applyStimulus(input logic we, input logic re, input logic [4:0] addr,
                                 input logic [31:0] wdata, input logic trap);
        bus_we     = we;
        bus_re     = re;
        bus_addr   = addr;
        bus_wdata  = wdata;
        trap_taken = trap;
        @(posedge clk);
        model_edge(we, re, addr, wdata, trap, ext_irq_in);
        #1;
        checkAll();
        bus_we     = 1'b0;
        bus_re     = 1'b0;
        trap_taken = 1'b0;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear before any edge.
    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_interrupt", interrupt, 1'b0);
        checkOutput("async_rst_cause", irq_cause, 5'd0);
        checkOutput("async_rst_mip", mip, 32'd0);
        checkOutput("async_rst_rdata", bus_rdata, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic        risen;
        logic        we;
        logic        re;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          pick;

        rst         = 1'b1;
        ext_irq_in  = 1'b0;
        bus_we      = 1'b0;
        bus_re      = 1'b0;
        bus_addr    = 5'd0;
        bus_wdata   = 32'd0;
        mstatus_mie = 1'b0;
        mie         = 32'd0;
        trap_taken  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_interrupt", interrupt, 1'b0);
        checkOutput("rst_cause", irq_cause, 5'd0);
        checkOutput("rst_mip", mip, 32'd0);
        checkOutput("rst_rdata", bus_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b1, 5'h08, 32'd0, 1'b0);
        checkOutput("rst_cmp_lo", bus_rdata, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 5'h0C, 32'd0, 1'b0);
        checkOutput("rst_cmp_hi", bus_rdata, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 5'h00, 32'd0, 1'b0);

        // Timer match at 20: request appears once mtime has moved on to 21.
        mie         = 32'h80;
        mstatus_mie = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'h0C, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'h08, 32'd20, 1'b0);
        risen = 1'b0;
        for (int i = 0; i < 60 && !risen; i++) begin
            applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);
            if (interrupt === 1'b1) risen = 1'b1;
        end
        checkOutput("timer_rise_seen", risen, 1'b1);
        checkOutput("timer_cause", irq_cause, 5'd7);
        applyStimulus(1'b0, 1'b1, 5'h00, 32'd0, 1'b0);
        checkOutput("timer_rise_mtime", bus_rdata, 32'd21);
        applyStimulus(1'b1, 1'b0, 5'h0C, 32'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);
        checkOutput("timer_fall", interrupt, 1'b0);

        // 64-bit wrap, with mtimecmp = 5 armed beforehand.
        applyStimulus(1'b1, 1'b0, 5'h08, 32'd5, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'h0C, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'h00, 32'hFFFF_FFFE, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'h04, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'h04, 32'd0, 1'b0);
        checkOutput("wrap_hi_before", bus_rdata, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 5'h00, 32'd0, 1'b0);
        checkOutput("wrap_lo_before", bus_rdata, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 5'h00, 32'd0, 1'b0);
        checkOutput("wrap_lo_after", bus_rdata, 32'd0);
        applyStimulus(1'b0, 1'b1, 5'h04, 32'd0, 1'b0);
        checkOutput("wrap_hi_after", bus_rdata, 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);

        // All three sources pending; walk the mask and global enable.
        ext_irq_in = 1'b1;
        mie        = 32'h888;
        applyStimulus(1'b1, 1'b0, 5'h10, 32'd1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);
        checkOutput("prio_mip", mip, 32'h888);
        checkOutput("prio_cause_mei", irq_cause, 5'd11);
        mie = 32'h088;
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);
        checkOutput("prio_cause_msi", irq_cause, 5'd3);
        mstatus_mie = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);
        checkOutput("mask_interrupt", interrupt, 1'b0);
        checkOutput("mask_mip", mip, 32'h888);

        // Hold window, with a second trap pulse in HOLD2 that must be ignored.
        mie         = 32'h800;
        mstatus_mie = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);
        checkOutput("hold_pre", interrupt, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b1);
        checkOutput("hold_1", interrupt, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);
        checkOutput("hold_2", interrupt, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b1);
        checkOutput("hold_3", interrupt, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b0);
        checkOutput("hold_end", interrupt, 1'b1);

        // Write/increment collision plus read-during-write returning old data.
        applyStimulus(1'b1, 1'b1, 5'h00, 32'd100, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'h00, 32'd0, 1'b0);
        checkOutput("collide_lo", bus_rdata, 32'd100);
        applyStimulus(1'b0, 1'b1, 5'h04, 32'd0, 1'b0);
        checkOutput("collide_hi", bus_rdata, 32'd0);

        // Reset landing in the middle of a hold.
        applyStimulus(1'b0, 1'b0, 5'h00, 32'd0, 1'b1);
        doReset();
        applyStimulus(1'b0, 1'b1, 5'h10, 32'd0, 1'b0);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                doReset();
            end else begin
                if ($urandom_range(0, 9) == 0) ext_irq_in = ~ext_irq_in;
                if ($urandom_range(0, 19) == 0) mie = $urandom;
                if ($urandom_range(0, 19) == 0) mstatus_mie = ($urandom_range(0, 3) != 0);
                we   = ($urandom_range(0, 3) == 0);
                re   = $urandom_range(0, 1) == 1;
                addr = 5'($urandom_range(0, 31));
                pick = $urandom_range(0, 3);
                if (addr[4:2] == 3'd1 || addr[4:2] == 3'd3)
                    wdata = (pick == 0) ? $urandom : 32'd0;
                else
                    wdata = (pick == 0) ? $urandom : m_mtime[31:0] + 32'($urandom_range(0, 40));
                applyStimulus(we, re, addr, wdata, $urandom_range(0, 7) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
